// File: rtl/map_x1_bank_irq_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// map_x1_bank_irq_if
// Bus bundle between the mapper top's decode logic and map_x1_bank_irq.
//
// Signals:
//   cpu_addr[15:0]  CPU address
//   cpu_dat[7:0]    CPU write data (also the data for save-state writes)
//   cpu_rw          1 = read, 0 = write
//   cpu_ce          1 = access outside the $8000-$FFFF ROM region
//   ppu_addr[13:0]  PPU address
//   ss_act          save-state engine active
//   ss_we           save-state write strobe
//   ss_addr[7:0]    save-state register index
//   ss_rdat[7:0]    save-state readback (combinational, driven by the core)
//
// Bus semantics: there is no valid/ready pair. A CPU write is a cycle with
// cpu_rw low and a register-window address, sampled on the falling edge of m2.
// A save-state write is ss_act and ss_we high, also sampled on that edge.
// Reads are purely combinational, so the core never stalls the bus.
//
// Modports: master = bus decode / save-state engine, slave = mapper core.
// -----------------------------------------------------------------------------
interface map_x1_bank_irq_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dat;
   logic        cpu_rw;
   logic        cpu_ce;
   logic [13:0] ppu_addr;
   logic        ss_act;
   logic        ss_we;
   logic [7:0]  ss_addr;
   logic [7:0]  ss_rdat;

   modport master (
      output cpu_addr, cpu_dat, cpu_rw, cpu_ce, ppu_addr, ss_act, ss_we, ss_addr,
      input  ss_rdat
   );

   modport slave (
      input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, ppu_addr, ss_act, ss_we, ss_addr,
      output ss_rdat
   );
endinterface

// File: rtl/map_x1_bank_irq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// map_x1_bank_irq
// X1-017 style bank mapper core: CHR/PRG bank registers, mirroring and A12
// inversion, key-protected WRAM slots, optional CPU-cycle IRQ down-counter,
// and full save-state read/write coverage.
//
// Optional feature macro: MAP_X1_IRQ_EN
//   defined   -> IRQ latch/counter/enable/reload/pending present.
//   undefined -> irq tied 0, register offsets D-F ignored, save-state
//                addresses 10-12 read 8'hFF and ignore writes.
//
// Ports:
//   m2           CPU clock; all state changes on its falling edge
//   map_rst      synchronous active-high reset
//   bus          map_x1_bank_irq_if.slave (CPU, PPU and save-state signals)
//   prg_addr_hi  PRG bank address bits (prg_addr[PRG_W+12:13])
//   chr_addr_hi  CHR bank address bits (chr_addr[CHR_W+9:10])
//   ciram_a10    nametable select
//   ram_ce       WRAM chip enable
//   ram_we       WRAM write enable
//   irq          registered IRQ request, active-high
// -----------------------------------------------------------------------------
module map_x1_bank_irq #(
   parameter int          PRG_W    = 6,
   parameter int          CHR_W    = 8,
   parameter int          IRQ_W    = 8,
   parameter logic [15:0] REG_BASE = 16'h7EF0,
   parameter logic [7:0]  MAP_IDX  = 8'd82
) (
   input  logic                  m2,
   input  logic                  map_rst,
   map_x1_bank_irq_if.slave      bus,
   output logic [PRG_W-1:0]      prg_addr_hi,
   output logic [CHR_W-1:0]      chr_addr_hi,
   output logic                  ciram_a10,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic                  irq
);

   // ---------------------------------------------------------------- state
   logic [CHR_W-2:0] chr2k [0:1];
   logic [CHR_W-1:0] chr1k [0:3];
   logic [PRG_W-1:0] prg   [0:2];
   logic             mirror;
   logic             a12_inv;
   logic [2:0]       ram_on;

   // ---------------------------------------------------------------- decode
   logic       reg_hit;
   logic [3:0] reg_off;
   logic       ss_wr;

   // The register window sits in WRAM slot 3, which never enables RAM.
   assign reg_hit = ({bus.cpu_addr[15:4], 4'h0} == REG_BASE) && !bus.cpu_rw && !bus.ss_act;
   assign reg_off = bus.cpu_addr[3:0];
   assign ss_wr   = bus.ss_act && bus.ss_we;

   // ------------------------------------------------------- bank registers
   always_ff @(negedge m2) begin
      if (map_rst) begin
         chr2k[0] <= '0;
         chr2k[1] <= '0;
         chr1k[0] <= '0;
         chr1k[1] <= '0;
         chr1k[2] <= '0;
         chr1k[3] <= '0;
         prg[0]   <= '0;
         prg[1]   <= '0;
         prg[2]   <= '0;
         mirror   <= 1'b0;
         a12_inv  <= 1'b0;
         ram_on   <= 3'b000;
      end else if (reg_hit) begin
         case (reg_off)
            4'h0: chr2k[0] <= (CHR_W-1)'(bus.cpu_dat[7:1]);
            4'h1: chr2k[1] <= (CHR_W-1)'(bus.cpu_dat[7:1]);
            4'h2: chr1k[0] <= CHR_W'(bus.cpu_dat);
            4'h3: chr1k[1] <= CHR_W'(bus.cpu_dat);
            4'h4: chr1k[2] <= CHR_W'(bus.cpu_dat);
            4'h5: chr1k[3] <= CHR_W'(bus.cpu_dat);
            4'h6: begin
               mirror  <= bus.cpu_dat[0];
               a12_inv <= bus.cpu_dat[1];
            end
            // Each slot has its own unlock key; any other value re-locks it.
            4'h7: ram_on[0] <= (bus.cpu_dat == 8'hCA);
            4'h8: ram_on[1] <= (bus.cpu_dat == 8'h69);
            4'h9: ram_on[2] <= (bus.cpu_dat == 8'h84);
            4'hA: prg[0] <= PRG_W'(bus.cpu_dat[7:2]);
            4'hB: prg[1] <= PRG_W'(bus.cpu_dat[7:2]);
            4'hC: prg[2] <= PRG_W'(bus.cpu_dat[7:2]);
            default: ;
         endcase
      end else if (ss_wr) begin
         case (bus.ss_addr)
            8'd0: chr2k[0] <= (CHR_W-1)'(bus.cpu_dat);
            8'd1: chr2k[1] <= (CHR_W-1)'(bus.cpu_dat);
            8'd2: chr1k[0] <= CHR_W'(bus.cpu_dat);
            8'd3: chr1k[1] <= CHR_W'(bus.cpu_dat);
            8'd4: chr1k[2] <= CHR_W'(bus.cpu_dat);
            8'd5: chr1k[3] <= CHR_W'(bus.cpu_dat);
            8'd6: prg[0]   <= PRG_W'(bus.cpu_dat);
            8'd7: prg[1]   <= PRG_W'(bus.cpu_dat);
            8'd8: prg[2]   <= PRG_W'(bus.cpu_dat);
            8'd9: begin
               mirror  <= bus.cpu_dat[0];
               a12_inv <= bus.cpu_dat[1];
               ram_on  <= bus.cpu_dat[4:2];
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ IRQ logic
   logic [7:0] irq_ss_rdat;   // readback for save-state addresses 10-12

`ifdef MAP_X1_IRQ_EN
   logic [IRQ_W-1:0] irq_latch;
   logic [IRQ_W-1:0] irq_cnt;
   logic             irq_en;
   logic             irq_reload;
   logic             irq_pend;

   always_ff @(negedge m2) begin
      if (map_rst) begin
         irq_latch  <= '0;
         irq_cnt    <= '0;
         irq_en     <= 1'b0;
         irq_reload <= 1'b0;
         irq_pend   <= 1'b0;
      end else begin
         // Count step uses the enable as it stood before this edge.
         if (irq_en && !bus.ss_act) begin
            if (irq_cnt != '0) begin
               irq_cnt <= irq_cnt - IRQ_W'(1);
            end else begin
               irq_pend <= 1'b1;
               if (irq_reload) irq_cnt <= irq_latch;
               else            irq_en  <= 1'b0;
            end
         end
         // Register and save-state writes come last so they win over the
         // count step on the same edge.
         if (reg_hit) begin
            case (reg_off)
               4'hD: irq_latch <= IRQ_W'(bus.cpu_dat);
               4'hE: begin
                  irq_en     <= bus.cpu_dat[0];
                  irq_reload <= bus.cpu_dat[1];
               end
               4'hF: begin
                  irq_pend <= 1'b0;
                  irq_cnt  <= irq_latch;
               end
               default: ;
            endcase
         end else if (ss_wr) begin
            case (bus.ss_addr)
               8'd10: irq_latch <= IRQ_W'(bus.cpu_dat);
               8'd11: irq_cnt   <= IRQ_W'(bus.cpu_dat);
               8'd12: begin
                  irq_en     <= bus.cpu_dat[0];
                  irq_reload <= bus.cpu_dat[1];
                  irq_pend   <= bus.cpu_dat[2];
               end
               default: ;
            endcase
         end
      end
   end

   assign irq = irq_pend;

   always_comb begin
      irq_ss_rdat = 8'hFF;
      case (bus.ss_addr)
         8'd10:   irq_ss_rdat = 8'(irq_latch);
         8'd11:   irq_ss_rdat = 8'(irq_cnt);
         8'd12:   irq_ss_rdat = {5'b0, irq_pend, irq_reload, irq_en};
         default: irq_ss_rdat = 8'hFF;
      endcase
   end
`else
   logic [IRQ_W-1:0] unused_irq_w;
   assign unused_irq_w = '0;
   assign irq          = 1'b0;
   assign irq_ss_rdat  = 8'hFF;
`endif

   // ----------------------------------------------------------- PRG mapping
   always_comb begin
      prg_addr_hi = '0;
      if (!bus.cpu_ce) begin
         case (bus.cpu_addr[14:13])
            2'd0:    prg_addr_hi = prg[0];
            2'd1:    prg_addr_hi = prg[1];
            2'd2:    prg_addr_hi = prg[2];
            default: prg_addr_hi = '1;
         endcase
      end
   end

   // ----------------------------------------------------------- CHR mapping
   logic [1:0] chr_bank;

   // A12 inversion swaps the 2K-bank half and the 1K-bank half of pattern space.
   assign chr_bank = a12_inv ? {!bus.ppu_addr[12], bus.ppu_addr[11]} : bus.ppu_addr[12:11];

   always_comb begin
      chr_addr_hi = '0;
      case (chr_bank)
         2'd0:    chr_addr_hi = {chr2k[0], bus.ppu_addr[10]};
         2'd1:    chr_addr_hi = {chr2k[1], bus.ppu_addr[10]};
         default: chr_addr_hi = chr1k[bus.ppu_addr[11:10]];
      endcase
   end

   assign ciram_a10 = mirror ? bus.ppu_addr[10] : bus.ppu_addr[11];

   // ------------------------------------------------------------------ WRAM
   logic slot_on;

   always_comb begin
      slot_on = 1'b0;
      case (bus.cpu_addr[12:11])
         2'd0:    slot_on = ram_on[0];
         2'd1:    slot_on = ram_on[1];
         2'd2:    slot_on = ram_on[2];
         default: slot_on = 1'b0;
      endcase
   end

   assign ram_ce = (bus.cpu_addr[15:13] == 3'b011) && slot_on;
   assign ram_we = ram_ce && !bus.cpu_rw;

   // ------------------------------------------------------- save-state read
   logic [7:0] ss_rdat_c;

   always_comb begin
      ss_rdat_c = 8'hFF;
      case (bus.ss_addr)
         8'd0:    ss_rdat_c = 8'(chr2k[0]);
         8'd1:    ss_rdat_c = 8'(chr2k[1]);
         8'd2:    ss_rdat_c = 8'(chr1k[0]);
         8'd3:    ss_rdat_c = 8'(chr1k[1]);
         8'd4:    ss_rdat_c = 8'(chr1k[2]);
         8'd5:    ss_rdat_c = 8'(chr1k[3]);
         8'd6:    ss_rdat_c = 8'(prg[0]);
         8'd7:    ss_rdat_c = 8'(prg[1]);
         8'd8:    ss_rdat_c = 8'(prg[2]);
         8'd9:    ss_rdat_c = {3'b0, ram_on, a12_inv, mirror};
         8'd10,
         8'd11,
         8'd12:   ss_rdat_c = irq_ss_rdat;
         8'd127:  ss_rdat_c = MAP_IDX;
         default: ss_rdat_c = 8'hFF;
      endcase
   end

   assign bus.ss_rdat = ss_rdat_c;

   // PPU A13 selects nametables, which this core does not decode.
   logic unused_ppu_a13;
   assign unused_ppu_a13 = bus.ppu_addr[13];

endmodule

// File: tb/tb_map_x1_bank_irq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_map_x1_bank_irq
// Directed bench for map_x1_bank_irq. Inputs change 1ns after each falling
// edge of m2 (the active edge); outputs are checked there, away from the edge.
// IRQ steps are built only when MAP_X1_IRQ_EN is defined; otherwise the bench
// checks that the IRQ path is absent.
// -----------------------------------------------------------------------------
module tb_map_x1_bank_irq;

   // ------------------------------------------------------- clock / reset
   logic m2;
   logic map_rst;

   initial begin
      m2 = 1'b1;
      forever #5 m2 = ~m2;
   end

   map_x1_bank_irq_if bus ();

   logic [5:0] prg_addr_hi;
   logic [7:0] chr_addr_hi;
   logic       ciram_a10;
   logic       ram_ce;
   logic       ram_we;
   logic       irq;

   map_x1_bank_irq dut (
      .m2          (m2),
      .map_rst     (map_rst),
      .bus         (bus),
      .prg_addr_hi (prg_addr_hi),
      .chr_addr_hi (chr_addr_hi),
      .ciram_a10   (ciram_a10),
      .ram_ce      (ram_ce),
      .ram_we      (ram_we),
      .irq         (irq)
   );

   // ---------------------------------------------------------- scoreboard
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // -------------------------------------------------------- driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge m2);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] dat);
      bus.cpu_addr = addr;
      bus.cpu_dat  = dat;
      bus.cpu_rw   = 1'b0;
      @(negedge m2);
      #1;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 16'h0000;
   endtask

   task automatic ss_write(input logic [7:0] addr, input logic [7:0] dat);
      bus.ss_addr = addr;
      bus.cpu_dat = dat;
      bus.ss_we   = 1'b1;
      @(negedge m2);
      #1;
      bus.ss_we   = 1'b0;
   endtask

   task automatic ss_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      bus.ss_addr = addr;
      #1;
      chk(tag, {8'h00, bus.ss_rdat}, {8'h00, exp});
   endtask

   task automatic ppu_chk(input string tag, input logic [13:0] addr, input logic [7:0] exp);
      bus.ppu_addr = addr;
      #1;
      chk(tag, {8'h00, chr_addr_hi}, {8'h00, exp});
   endtask

   task automatic ram_chk(input string tag, input logic [15:0] addr, input logic rw,
                          input logic exp_ce, input logic exp_we);
      bus.cpu_addr = addr;
      bus.cpu_rw   = rw;
      #1;
      chk({tag, "_ce"}, {15'h0, ram_ce}, {15'h0, exp_ce});
      chk({tag, "_we"}, {15'h0, ram_we}, {15'h0, exp_we});
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 16'h0000;
   endtask

   task automatic prg_chk(input string tag, input logic [15:0] addr, input logic ce,
                          input logic [5:0] exp);
      bus.cpu_addr = addr;
      bus.cpu_ce   = ce;
      #1;
      chk(tag, {10'h0, prg_addr_hi}, {10'h0, exp});
      bus.cpu_addr = 16'h0000;
      bus.cpu_ce   = 1'b1;
   endtask

   // --------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      bus.cpu_addr = 16'h0000;
      bus.cpu_dat  = 8'h00;
      bus.cpu_rw   = 1'b1;
      bus.cpu_ce   = 1'b1;
      bus.ppu_addr = 14'h0000;
      bus.ss_act   = 1'b0;
      bus.ss_we    = 1'b0;
      bus.ss_addr  = 8'h00;
      map_rst      = 1'b1;
      tick(2);
      map_rst      = 1'b0;

      // Reset state
      chk("rst_irq", {15'h0, irq}, 16'h0);
      prg_chk("rst_prg", 16'h8000, 1'b0, 6'h00);
      ss_chk("rst_ss0", 8'd0, 8'h00);
      ss_chk("rst_ss9", 8'd9, 8'h00);
      ram_chk("rst_ram", 16'h6000, 1'b1, 1'b0, 1'b0);
      bus.ppu_addr = 14'h0800;
      #1;
      chk("rst_ciram", {15'h0, ciram_a10}, 16'h1);   // mirror=0 -> ppu A11

      // CHR mapping: 2K reg0 = $0A>>1 = $05, 1K reg2 = $33, A12 inverted
      cpu_write(16'h7EF0, 8'h0A);
      cpu_write(16'h7EF2, 8'h33);
      cpu_write(16'h7EF3, 8'h44);
      cpu_write(16'h7EF6, 8'h02);
      ppu_chk("chr_inv_0000", 14'h0000, 8'h33);
      ppu_chk("chr_inv_1400", 14'h1400, 8'h0B);
      ppu_chk("chr_inv_0400", 14'h0400, 8'h44);
      cpu_write(16'h7EF6, 8'h00);
      ppu_chk("chr_1000", 14'h1000, 8'h33);
      ppu_chk("chr_1400", 14'h1400, 8'h44);
      ppu_chk("chr_0400", 14'h0400, 8'h0B);
      ss_chk("ss_chr2k0", 8'd0, 8'h05);

      // Mirroring: mirror=1 selects ppu A10
      cpu_write(16'h7EF6, 8'h01);
      bus.ppu_addr = 14'h0400;
      #1;
      chk("ciram_h_0400", {15'h0, ciram_a10}, 16'h1);
      bus.ppu_addr = 14'h0800;
      #1;
      chk("ciram_h_0800", {15'h0, ciram_a10}, 16'h0);

      // RAM keys
      cpu_write(16'h7EF7, 8'hCA);
      ram_chk("ram0_rd", 16'h6100, 1'b1, 1'b1, 1'b0);
      ram_chk("ram0_wr", 16'h6100, 1'b0, 1'b1, 1'b1);
      ram_chk("ram1_locked", 16'h6900, 1'b1, 1'b0, 1'b0);
      cpu_write(16'h7EF8, 8'h69);
      ram_chk("ram1_open", 16'h6900, 1'b1, 1'b1, 1'b0);
      ram_chk("ram_slot3", 16'h7800, 1'b0, 1'b0, 1'b0);
      cpu_write(16'h7EF7, 8'hCB);
      ram_chk("ram0_relock", 16'h6100, 1'b1, 1'b0, 1'b0);
      ss_chk("ss_flags", 8'd9, 8'h09);   // ram_on1, mirror

      // PRG mapping
      cpu_write(16'h7EFA, 8'h14);
      prg_chk("prg_8000", 16'h8000, 1'b0, 6'h05);
      prg_chk("prg_e000", 16'hE000, 1'b0, 6'h3F);
      prg_chk("prg_ce1", 16'h8000, 1'b1, 6'h00);
      cpu_write(16'h7EFB, 8'hFF);
      prg_chk("prg_a000", 16'hA000, 1'b0, 6'h3F);
      ss_chk("ss_prg1", 8'd7, 8'h3F);
      // Register writes are frozen while the save-state engine is active
      bus.ss_act = 1'b1;
      cpu_write(16'h7EFA, 8'h08);
      bus.ss_act = 1'b0;
      prg_chk("prg_frozen", 16'h8000, 1'b0, 6'h05);

      ss_chk("ss_map_idx", 8'd127, 8'd82);
      ss_chk("ss_unmapped13", 8'd13, 8'hFF);
      ss_chk("ss_unmapped200", 8'd200, 8'hFF);

`ifdef MAP_X1_IRQ_EN
      // IRQ one-shot: latch 3, enable -> irq rises on 4th edge after enable
      cpu_write(16'h7EFD, 8'h03);
      cpu_write(16'h7EFF, 8'h00);
      cpu_write(16'h7EFE, 8'h01);
      tick(3);
      chk("os_pre", {15'h0, irq}, 16'h0);
      tick(1);
      chk("os_rise", {15'h0, irq}, 16'h1);
      ss_chk("os_ctrl", 8'd12, 8'h04);   // pending=1, reload=0, en=0
      ss_chk("os_latch", 8'd10, 8'h03);
      cpu_write(16'h7EFF, 8'h00);
      chk("os_ack", {15'h0, irq}, 16'h0);

      // IRQ auto-reload: latch 2 -> pending every 3 edges
      cpu_write(16'h7EFD, 8'h02);
      cpu_write(16'h7EFF, 8'h00);
      cpu_write(16'h7EFE, 8'h03);
      tick(2);
      chk("ar_pre", {15'h0, irq}, 16'h0);
      tick(1);
      chk("ar_rise1", {15'h0, irq}, 16'h1);
      cpu_write(16'h7EFF, 8'h00);
      chk("ar_ack1", {15'h0, irq}, 16'h0);
      tick(2);
      chk("ar_mid", {15'h0, irq}, 16'h0);
      tick(1);
      chk("ar_rise2", {15'h0, irq}, 16'h1);
      cpu_write(16'h7EFF, 8'h00);
      tick(2);
      chk("ar_cnt0", {15'h0, irq}, 16'h0);
      // Ack coincident with expiry: the ack wins
      cpu_write(16'h7EFF, 8'h00);
      chk("ar_coincide", {15'h0, irq}, 16'h0);
      ss_chk("ar_cnt_reload", 8'd11, 8'h02);
      tick(1);
      chk("ar_after", {15'h0, irq}, 16'h0);

      // Save state: counting frozen while active
      bus.ss_act = 1'b1;
      ss_write(8'd11, 8'h05);
      ss_write(8'd0, 8'h7F);
      ss_write(8'd12, 8'h03);
      tick(10);
      ss_chk("ss_cnt_frozen", 8'd11, 8'h05);
      ss_chk("ss_chr_wr", 8'd0, 8'h7F);
      ss_chk("ss_ctrl_wr", 8'd12, 8'h03);
      bus.ss_act = 1'b0;
      ppu_chk("ss_chr_map", 14'h0000, 8'hFE);
      tick(2);
      ss_chk("ss_cnt_run", 8'd11, 8'h03);
      bus.ss_act = 1'b1;
      ss_write(8'd12, 8'h07);
      bus.ss_act = 1'b0;
      chk("ss_pend_set", {15'h0, irq}, 16'h1);
      // Reset mid-count
      map_rst = 1'b1;
      tick(1);
      map_rst = 1'b0;
      chk("rst_mid_irq", {15'h0, irq}, 16'h0);
      ss_chk("rst_mid_cnt", 8'd11, 8'h00);
      ss_chk("rst_mid_ctrl", 8'd12, 8'h00);
`else
      // IRQ absent: offsets D-F and save-state 10-12 have no effect
      cpu_write(16'h7EFD, 8'h01);
      cpu_write(16'h7EFF, 8'h00);
      cpu_write(16'h7EFE, 8'h03);
      tick(5);
      chk("noirq_irq", {15'h0, irq}, 16'h0);
      ss_chk("noirq_ss10", 8'd10, 8'hFF);
      bus.ss_act = 1'b1;
      ss_write(8'd11, 8'h05);
      ss_write(8'd0, 8'h7F);
      ss_write(8'd12, 8'h07);
      tick(10);
      bus.ss_act = 1'b0;
      ss_chk("noirq_ss11", 8'd11, 8'hFF);
      ss_chk("noirq_ss12", 8'd12, 8'hFF);
      ss_chk("ss_chr_wr", 8'd0, 8'h7F);
      ppu_chk("ss_chr_map", 14'h0000, 8'hFE);
      chk("noirq_irq2", {15'h0, irq}, 16'h0);
      map_rst = 1'b1;
      tick(1);
      map_rst = 1'b0;
      ss_chk("rst_mid_chr", 8'd0, 8'h00);
      chk("rst_mid_irq", {15'h0, irq}, 16'h0);
`endif
      prg_chk("rst_mid_prg", 16'h8000, 1'b0, 6'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
